fifo_stream_reader: RTL

Read-side master for the team's shift-list FIFO. It drives the FIFO's `rd_en`, captures the `rd_data` / `rd_val` response one cycle later, and buffers words in a 3-entry skid buffer. It re-emits them on a valid/ready stream with packet framing (`m_last` every `PKT_LEN` words). It sits between a FIFO instance and any downstream consumer that needs backpressure instead of the FIFO's read-pulse protocol.

---
 rtl/fifo_stream_reader.sv | 63 ++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drives a read-pulse FIFO and re-emits its words on a
// framed valid/ready stream through a 3-entry skid buffer.
module fifo_stream_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int PKT_LEN      = 4,
    parameter int IDLE_BACKOFF = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_val,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [15:0]           pkt_cnt,
    output logic                  busy
);
    logic [1:0]            r_inflight, r_occ, r_wr_ptr, r_rd_ptr;
    logic [15:0]           r_backoff, r_word_idx, r_pkt_cnt;
    logic [DATA_WIDTH-1:0] r_buf [3];
    logic                  w_resp, w_push, w_pop, w_last;

    // A response is only meaningful in the cycle right after a read request.
    assign w_resp  = r_inflight != 2'd0;
    assign w_push  = w_resp & rd_val;
    assign m_valid = r_occ != 2'd0;
    assign w_pop   = m_valid & m_ready;
    assign w_last  = r_word_idx == 16'(PKT_LEN - 1);
    assign rd_en   = ~reset & enable & (r_backoff == 16'd0) &
                     (({1'b0, r_occ} + {1'b0, r_inflight}) < 3'd3);
    assign m_data  = m_valid ? r_buf[r_rd_ptr] : '0;
    assign m_last  = m_valid & w_last;
    assign pkt_cnt = r_pkt_cnt;
    assign busy    = (r_inflight != 2'd0) | m_valid;

    always_ff @(posedge clk) begin
        if (w_push) r_buf[r_wr_ptr] <= rd_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight <= '0;
            r_occ      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_backoff  <= '0;
            r_word_idx <= '0;
            r_pkt_cnt  <= '0;
        end else begin
            r_inflight <= r_inflight + {1'b0, rd_en} - {1'b0, w_resp};
            r_occ      <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push) r_wr_ptr <= (r_wr_ptr == 2'd2) ? 2'd0 : r_wr_ptr + 2'd1;
            if (w_pop) r_rd_ptr <= (r_rd_ptr == 2'd2) ? 2'd0 : r_rd_ptr + 2'd1;
            if (w_resp & ~rd_val) r_backoff <= 16'(IDLE_BACKOFF);
            else if (r_backoff != 16'd0) r_backoff <= r_backoff - 16'd1;
            if (w_pop) r_word_idx <= w_last ? 16'd0 : r_word_idx + 16'd1;
            if (w_pop & w_last) r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
    end
endmodule
